// File: rtl/disp_pkg.sv
// Shared types, constants and segment decode for the multiplexed display controller.
package disp_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned BCD_W      = 12;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    typedef logic [1:0] digit_idx_t;

    // Active-low {g,f,e,d,c,b,a}; 10..15 give the hex glyphs A b C d E F.
    function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] d);
        case (d)
            4'h0:    seg_decode = 7'b1000000;
            4'h1:    seg_decode = 7'b1111001;
            4'h2:    seg_decode = 7'b0100100;
            4'h3:    seg_decode = 7'b0110000;
            4'h4:    seg_decode = 7'b0011001;
            4'h5:    seg_decode = 7'b0010010;
            4'h6:    seg_decode = 7'b0000010;
            4'h7:    seg_decode = 7'b1111000;
            4'h8:    seg_decode = 7'b0000000;
            4'h9:    seg_decode = 7'b0010000;
            4'hA:    seg_decode = 7'b0001000;
            4'hB:    seg_decode = 7'b0000011;
            4'hC:    seg_decode = 7'b1000110;
            4'hD:    seg_decode = 7'b0100001;
            4'hE:    seg_decode = 7'b0000110;
            default: seg_decode = 7'b0001110;
        endcase
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_bin2bcd_seq.sv
// Iterative 8-bit double-dabble: start loads the operand, one shift per cycle,
// done_c flags the final shift; bcd is valid from the following cycle.
module bin2bcd_seq
    import disp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] bin,
    output logic              done_c,
    output logic [BCD_W-1:0]  bcd
);

    localparam int unsigned SR_W  = BCD_W + DATA_W;
    localparam int unsigned CNT_W = $clog2(DATA_W);

    logic [SR_W-1:0]  sreg;
    logic [SR_W-1:0]  sreg_adj;
    logic [CNT_W-1:0] cnt;
    logic             running;

    // Add-3 correction on every BCD nibble that would overflow on the shift.
    always_comb begin
        sreg_adj = sreg;
        for (int i = 0; i < int'(BCD_W / 4); i++) begin
            if (sreg[DATA_W + 4*i +: 4] >= 4'd5)
                sreg_adj[DATA_W + 4*i +: 4] = sreg[DATA_W + 4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg    <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            sreg    <= {BCD_W'(0), bin};
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            sreg <= {sreg_adj[SR_W-2:0], 1'b0};
            cnt  <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_W - 1))
                running <= 1'b0;
        end
    end

    assign done_c = running && (cnt == CNT_W'(DATA_W - 1));
    assign bcd    = sreg[SR_W-1 -: BCD_W];

endmodule

// File: rtl/disp_scan_ctrl.sv
// Four-digit seven-segment scan controller with scheduled binary-to-decimal update.
// Optional HEX_MODE_EN adds a hex_mode input for two-digit hex display.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     out_val,
    input  logic                  out_load,
    input  logic [DATA_W-1:0]     bus_val,
    input  logic                  src_sel,
    input  logic                  signed_mode,
`ifdef HEX_MODE_EN
    input  logic                  hex_mode,
`endif
    output logic [SEG_W-1:0]      display,
    output logic [NUM_DIGITS-1:0] digit_select,
    output logic                  busy
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    state_t            state, state_nxt;
    logic [PW-1:0]     presc;
    digit_idx_t        idx, idx_nxt;
    logic              tc;
    logic              hex_now, src_q, sgn_q, hex_q;
    logic [DATA_W-1:0] last_bus, raw_c, trig_mag_c;
    logic              trig_c, trig_neg_c;
    logic              go_c, go_neg_c, go_hex_c, start_c, commit_c, pend_set_c, pend_clr_c;
    logic [DATA_W-1:0] go_mag_c;
    logic              pend, pend_neg, pend_hex;
    logic [DATA_W-1:0] pend_mag;
    logic              cur_neg, cur_hex;
    logic [DATA_W-1:0] cur_mag;
    logic [3:0]        d0, d1, d2, d0_nxt, d1_nxt, d2_nxt;
    logic              neg_s, hex_s, neg_nxt, hex_nxt;
    logic              conv_done_c;
    logic [BCD_W-1:0]  bcd;

`ifdef HEX_MODE_EN
    assign hex_now = hex_mode;
`else
    assign hex_now = 1'b0;
`endif

    assign tc      = (presc == PW'(REFRESH_DIV - 1));
    assign idx_nxt = tc ? idx + digit_idx_t'(1) : idx;

    // Trigger sources: mode/source change, CPU load, or a changed bus value at frame wrap.
    assign raw_c      = src_sel ? bus_val : out_val;
    assign trig_c     = (src_sel != src_q) || (signed_mode != sgn_q) || (hex_now != hex_q) ||
                        (src_sel ? (tc && idx == digit_idx_t'(NUM_DIGITS - 1) && bus_val != last_bus)
                                 : out_load);
    assign trig_neg_c = !hex_now && signed_mode && raw_c[DATA_W-1];
    assign trig_mag_c = trig_neg_c ? -raw_c : raw_c;

    bin2bcd_seq u_bin2bcd (
        .clk    (clk),
        .rst    (rst),
        .start  (start_c),
        .bin    (go_mag_c),
        .done_c (conv_done_c),
        .bcd    (bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A trigger arriving in COMMIT supersedes any older pending value.
    always_comb begin
        state_nxt  = state;
        go_c       = 1'b0;
        go_mag_c   = trig_mag_c;
        go_neg_c   = trig_neg_c;
        go_hex_c   = hex_now;
        commit_c   = 1'b0;
        pend_set_c = 1'b0;
        pend_clr_c = 1'b0;
        case (state)
            IDLE:  go_c = trig_c;
            SHIFT: begin
                pend_set_c = trig_c;
                if (conv_done_c) state_nxt = COMMIT;
            end
            COMMIT: begin
                commit_c   = 1'b1;
                pend_clr_c = 1'b1;
                go_c       = trig_c || pend;
                state_nxt  = IDLE;
                if (!trig_c) begin
                    go_mag_c = pend_mag;
                    go_neg_c = pend_neg;
                    go_hex_c = pend_hex;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (go_c) state_nxt = go_hex_c ? COMMIT : SHIFT;
        start_c = go_c && !go_hex_c;
    end

    always_comb begin
        d0_nxt  = d0;
        d1_nxt  = d1;
        d2_nxt  = d2;
        neg_nxt = neg_s;
        hex_nxt = hex_s;
        if (commit_c) begin
            neg_nxt = cur_neg;
            hex_nxt = cur_hex;
            if (cur_hex) begin
                d0_nxt = cur_mag[3:0];
                d1_nxt = cur_mag[7:4];
                d2_nxt = 4'd0;
            end else begin
                d0_nxt = bcd[3:0];
                d1_nxt = bcd[7:4];
                d2_nxt = bcd[11:8];
            end
        end
    end

    function automatic logic [SEG_W-1:0] glyph(input digit_idx_t i, input logic [3:0] o,
                                               input logic [3:0] t, input logic [3:0] h,
                                               input logic neg, input logic hex);
        glyph = SEG_BLANK;
        case (i)
            2'd0:    glyph = seg_decode(o);
            2'd1:    if (hex || h != 4'd0 || t != 4'd0) glyph = seg_decode(t);
            2'd2:    if (!hex && h != 4'd0) glyph = seg_decode(h);
            default: if (!hex && neg) glyph = SEG_MINUS;
        endcase
    endfunction

    // Outputs are driven from next-state values so a commit shows on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc        <= '0;
            idx          <= '0;
            src_q        <= src_sel;
            sgn_q        <= signed_mode;
            hex_q        <= hex_now;
            last_bus     <= '0;
            pend         <= 1'b0;
            pend_mag     <= '0;
            pend_neg     <= 1'b0;
            pend_hex     <= 1'b0;
            cur_mag      <= '0;
            cur_neg      <= 1'b0;
            cur_hex      <= 1'b0;
            d0           <= '0;
            d1           <= '0;
            d2           <= '0;
            neg_s        <= 1'b0;
            hex_s        <= 1'b0;
            display      <= seg_decode(4'd0);
            digit_select <= 4'b1110;
            busy         <= 1'b0;
        end else begin
            presc <= tc ? '0 : presc + PW'(1);
            idx   <= idx_nxt;
            src_q <= src_sel;
            sgn_q <= signed_mode;
            hex_q <= hex_now;
            if (trig_c && src_sel) last_bus <= bus_val;
            if (pend_set_c) begin
                pend     <= 1'b1;
                pend_mag <= trig_mag_c;
                pend_neg <= trig_neg_c;
                pend_hex <= hex_now;
            end else if (pend_clr_c) begin
                pend <= 1'b0;
            end
            if (go_c) begin
                cur_mag <= go_mag_c;
                cur_neg <= go_neg_c;
                cur_hex <= go_hex_c;
            end
            d0           <= d0_nxt;
            d1           <= d1_nxt;
            d2           <= d2_nxt;
            neg_s        <= neg_nxt;
            hex_s        <= hex_nxt;
            display      <= glyph(idx_nxt, d0_nxt, d1_nxt, d2_nxt, neg_nxt, hex_nxt);
            digit_select <= ~(NUM_DIGITS'(1) << idx_nxt);
            busy         <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl: expected frames queued at stimulus, compared on commit.
`timescale 1ns/1ps
module tb_disp_scan_ctrl;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] out_val;
    logic       out_load;
    logic [7:0] bus_val;
    logic       src_sel;
    logic       signed_mode;
`ifdef HEX_MODE_EN
    logic       hex_mode;
`endif
    logic [6:0] display;
    logic [3:0] digit_select;
    logic       busy;

    int nchk  = 0;
    int npass = 0;
    int nfail = 0;
    logic [27:0] sb[$];
    logic [27:0] shown;

    always #5 clk = ~clk;

    disp_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .out_val      (out_val),
        .out_load     (out_load),
        .bus_val      (bus_val),
        .src_sel      (src_sel),
        .signed_mode  (signed_mode),
`ifdef HEX_MODE_EN
        .hex_mode     (hex_mode),
`endif
        .display      (display),
        .digit_select (digit_select),
        .busy         (busy)
    );

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: seg = 7'b1000000;
            1: seg = 7'b1111001;
            2: seg = 7'b0100100;
            3: seg = 7'b0110000;
            4: seg = 7'b0011001;
            5: seg = 7'b0010010;
            6: seg = 7'b0000010;
            7: seg = 7'b1111000;
            8: seg = 7'b0000000;
            9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    endfunction

    // Reference frame {digit3,digit2,digit1,digit0} from plain integer arithmetic.
    function automatic logic [27:0] model(input logic [7:0] v, input logic sgn);
        int n, h, t, o;
        logic neg;
        logic [6:0] g0, g1, g2, g3;
        neg = sgn && v[7];
        n = neg ? 256 - int'(v) : int'(v);
        h = n / 100;
        t = (n / 10) % 10;
        o = n % 10;
        g0 = seg(o);
        g1 = (h == 0 && t == 0) ? 7'b1111111 : seg(t);
        g2 = (h == 0) ? 7'b1111111 : seg(h);
        g3 = neg ? 7'b0111111 : 7'b1111111;
        return {g3, g2, g1, g0};
    endfunction

    function automatic int slot(input logic [3:0] ds);
        case (ds)
            4'b1110: slot = 0;
            4'b1101: slot = 1;
            4'b1011: slot = 2;
            4'b0111: slot = 3;
            default: slot = -1;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_slot(input string tag, input logic [27:0] frame);
        int s;
        s = slot(digit_select);
        if (s < 0) chk({tag, "_sel"}, 32'(digit_select), 32'hE);
        else       chk(tag, 32'(display), 32'(frame[7*s +: 7]));
    endtask

    task automatic hold(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            cmp_slot(tag, shown);
            tick;
        end
    endtask

    task automatic pop_frame(input string tag);
        chk({tag, "_sb_empty"}, 32'(sb.size() == 0), 32'd0);
        if (sb.size() != 0) shown = sb.pop_front();
    endtask

    task automatic check_frame(input string tag);
        pop_frame(tag);
        hold(tag, 4 * DIV);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 200) begin
            tick;
            k++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic load(input logic [7:0] v);
        out_val  = v;
        out_load = 1'b1;
        tick;
        out_load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ds_exp, ds_prev;
        int k;
        rst = 1'b1; out_val = '0; out_load = 1'b0; bus_val = '0;
        src_sel = 1'b0; signed_mode = 1'b0;
`ifdef HEX_MODE_EN
        hex_mode = 1'b0;
`endif
        shown = model(8'd0, 1'b0);

        // Reset state and scan order.
        tick; tick;
        chk("rst_sel", 32'(digit_select), 32'b1110);
        chk("rst_disp", 32'(display), 32'b1000000);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        for (int d = 1; d <= 4; d++) begin
            ds_prev = ~(4'b0001 << ((d - 1) % 4));
            ds_exp  = ~(4'b0001 << (d % 4));
            tick; tick; tick;
            chk("scan_hold", 32'(digit_select), 32'(ds_prev));
            tick;
            chk("scan_sel", 32'(digit_select), 32'(ds_exp));
            chk("scan_disp", 32'(display), (d % 4 == 0) ? 32'b1000000 : 32'b1111111);
        end
        sb.push_back(model(8'd0, 1'b0));
        check_frame("rst_frame");

        // Unsigned load: busy for exactly 9 cycles, digits valid at T+10.
        sb.push_back(model(8'd173, 1'b0));
        load(8'd173);
        for (int i = 0; i < 9; i++) begin
            chk("busy_173", 32'(busy), 32'd1);
            tick;
        end
        chk("busy_173_end", 32'(busy), 32'd0);
        check_frame("u173");

        // Signed mode: the mode change itself reconverts, then -10 and -128.
        signed_mode = 1'b1;
        sb.push_back(model(8'd173, 1'b1));
        tick;
        wait_idle("sgn_on");
        check_frame("s_modechg");
        sb.push_back(model(8'hF6, 1'b1));
        load(8'hF6);
        wait_idle("s_f6");
        check_frame("s_m10");
        sb.push_back(model(8'h80, 1'b1));
        load(8'h80);
        wait_idle("s_80");
        check_frame("s_m128");
        signed_mode = 1'b0;
        sb.push_back(model(8'h80, 1'b0));
        tick;
        wait_idle("sgn_off");
        check_frame("u128");

        // Back-to-back loads: 42 is overwritten by 99 while 5 converts.
        sb.push_back(model(8'd5, 1'b0));
        sb.push_back(model(8'd99, 1'b0));
        load(8'd5); load(8'd42); load(8'd99);
        hold("pend_old", 7);
        pop_frame("pend_5");
        chk("pend_busy", 32'(busy), 32'd1);
        hold("pend_5", 9);
        chk("pend_busy_end", 32'(busy), 32'd0);
        check_frame("pend_99");

        // Bus source: change waits for the frame wrap.
        bus_val = 8'd7;
        tick;
        chk("bus_noload", 32'(busy), 32'd0);
        src_sel = 1'b1;
        sb.push_back(model(8'd7, 1'b0));
        tick;
        wait_idle("bus_sel");
        check_frame("bus7");
        k = 0;
        while (digit_select !== 4'b1101 && k < 64) begin tick; k++; end
        chk("bus_sync", 32'(digit_select), 32'b1101);
        bus_val = 8'd200;
        sb.push_back(model(8'd200, 1'b0));
        k = 0;
        while (digit_select !== 4'b1110 && k < 64) begin
            chk("bus_prewrap_busy", 32'(busy), 32'd0);
            cmp_slot("bus_prewrap", shown);
            tick;
            k++;
        end
        chk("bus_wrap", 32'(digit_select), 32'b1110);
        chk("bus_wrap_busy", 32'(busy), 32'd1);
        hold("bus_hold", 9);
        chk("bus_done", 32'(busy), 32'd0);
        check_frame("bus200");
        for (int i = 0; i < 40; i++) begin
            chk("bus_stable", 32'(busy), 32'd0);
            tick;
        end

        src_sel = 1'b0;
        sb.push_back(model(8'd99, 1'b0));
        tick;
        wait_idle("src_back");
        check_frame("back_out");

        // Reset in the 4th SHIFT cycle with a pending value queued.
        load(8'd200); load(8'd55);
        tick; tick;
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_disp", 32'(display), 32'b1000000);
        chk("mid_rst_sel", 32'(digit_select), 32'b1110);
        rst = 1'b0;
        sb.push_back(model(8'd0, 1'b0));
        check_frame("mid_zero");
        sb.push_back(model(8'd10, 1'b0));
        load(8'd10);
        for (int i = 0; i < 9; i++) tick;
        chk("post_rst_busy", 32'(busy), 32'd0);
        check_frame("post_rst_10");

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
